// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } piso_state_t;

    function automatic int unsigned calc_num_sym(input int unsigned size_in,
                                                 input int unsigned size_out);
        return size_in / size_out;
    endfunction

    // Keep at least one bit so degenerate sizes still elaborate before the checks fire.
    function automatic int unsigned calc_cnt_w(input int unsigned size_in,
                                               input int unsigned size_out);
        int unsigned n;
        n = size_in / size_out;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Start/data request and symbol/valid/done response of the serializer.
interface piso_serializer_if #(
    parameter int unsigned SIZE_DATA_IN  = 16,
    parameter int unsigned SIZE_DATA_OUT = 2
);

    logic                     i_start;
    logic [SIZE_DATA_IN-1:0]  i_data;
    logic [SIZE_DATA_OUT-1:0] o_data;
    logic                     o_valid;
    logic                     o_done;

    modport master (
        output i_start,
        output i_data,
        input  o_data,
        input  o_valid,
        input  o_done
    );

    modport slave (
        input  i_start,
        input  i_data,
        output o_data,
        output o_valid,
        output o_done
    );

endinterface

// File: rtl/piso_serializer_sym_counter.sv
// Modulo-NUM_SYM symbol counter with load/enable; o_tc flags the final symbol index.
module piso_sym_counter
    import piso_pkg::*;
#(
    parameter int unsigned NUM_SYM = 8,
    parameter int unsigned CNT_W   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_SYM - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LastIdx);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: one SIZE_DATA_OUT-bit symbol per clock, MSB symbol first.
// Define PISO_LSB_FIRST_EN to emit the least-significant symbol first instead.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned SIZE_DATA_IN  = 16,
    parameter int unsigned SIZE_DATA_OUT = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    piso_serializer_if.slave   bus
);

    localparam int unsigned NUM_SYM = calc_num_sym(SIZE_DATA_IN, SIZE_DATA_OUT);
    localparam int unsigned CNT_W   = calc_cnt_w(SIZE_DATA_IN, SIZE_DATA_OUT);

    if (SIZE_DATA_IN % SIZE_DATA_OUT != 0) begin : g_bad_ratio
        $error("SIZE_DATA_IN must be an integer multiple of SIZE_DATA_OUT");
    end
    if (NUM_SYM < 2) begin : g_bad_num_sym
        $error("SIZE_DATA_IN/SIZE_DATA_OUT must be at least 2");
    end

    piso_state_t              state_q, state_d;
    logic [SIZE_DATA_IN-1:0]  shreg_q, shreg_d;
    logic [SIZE_DATA_OUT-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;

    logic                     cnt_load, cnt_en, cnt_tc;
    logic [SIZE_DATA_OUT-1:0] cap_sym, nxt_sym;
    logic [SIZE_DATA_IN-1:0]  cap_rest, nxt_rest;

`ifdef PISO_LSB_FIRST_EN
    assign cap_sym  = bus.i_data[SIZE_DATA_OUT-1:0];
    assign cap_rest = bus.i_data >> SIZE_DATA_OUT;
    assign nxt_sym  = shreg_q[SIZE_DATA_OUT-1:0];
    assign nxt_rest = shreg_q >> SIZE_DATA_OUT;
`else
    assign cap_sym  = bus.i_data[SIZE_DATA_IN-1 -: SIZE_DATA_OUT];
    assign cap_rest = bus.i_data << SIZE_DATA_OUT;
    assign nxt_sym  = shreg_q[SIZE_DATA_IN-1 -: SIZE_DATA_OUT];
    assign nxt_rest = shreg_q << SIZE_DATA_OUT;
`endif

    piso_sym_counter #(
        .NUM_SYM (NUM_SYM),
        .CNT_W   (CNT_W)
    ) u_sym_counter (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (CNT_W'(1)),
        .tc_o       (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d  = SHIFT;
                    data_d   = cap_sym;
                    shreg_d  = cap_rest;
                    valid_d  = 1'b1;
                    cnt_load = 1'b1;
                end else begin
                    data_d  = '0;
                    valid_d = 1'b0;
                end
            end
            SHIFT: begin
                // done_q marks the edge after the last symbol: a new word may start back-to-back.
                if (done_q) begin
                    if (bus.i_start) begin
                        data_d   = cap_sym;
                        shreg_d  = cap_rest;
                        valid_d  = 1'b1;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        data_d  = '0;
                        shreg_d = '0;
                        valid_d = 1'b0;
                    end
                end else begin
                    data_d  = nxt_sym;
                    shreg_d = nxt_rest;
                    cnt_en  = 1'b1;
                    done_d  = cnt_tc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_done  = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: queue-based symbol-stream model plus directed literals.
module tb_piso_serializer;

    localparam int unsigned IN   = 16;
    localparam int unsigned OUT  = 2;
    localparam int unsigned NSYM = IN / OUT;

`ifdef PISO_LSB_FIRST_EN
    localparam logic [IN-1:0] Seq1234 = 16'h1C84;
`else
    localparam logic [IN-1:0] Seq1234 = 16'h1234;
`endif
    localparam logic [IN-1:0] SeqAAAA = 16'hAAAA;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piso_serializer_if #(.SIZE_DATA_IN(IN), .SIZE_DATA_OUT(OUT)) bus ();

    piso_serializer #(
        .SIZE_DATA_IN  (IN),
        .SIZE_DATA_OUT (OUT)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Symbol k of a word in emission order.
    function automatic logic [OUT-1:0] sym_of(input logic [IN-1:0] w, input int k);
`ifdef PISO_LSB_FIRST_EN
        return OUT'(w >> (OUT * k));
`else
        return OUT'(w >> (IN - OUT * (k + 1)));
`endif
    endfunction

    // Model: a word becomes a queue of pending symbols; one pops per cycle.
    logic [OUT-1:0] pend_q[$];
    logic [OUT-1:0] m_data  = '0;
    logic           m_valid = 1'b0;
    logic           m_done  = 1'b0;
    bit             m_live  = 1'b0;

    always @(posedge clk) begin
        logic [OUT-1:0] nd;
        logic           nv, ndn;
        nd  = '0;
        nv  = 1'b0;
        ndn = 1'b0;
        if (rst) begin
            pend_q.delete();
            m_live <= 1'b1;
        end else begin
            if (pend_q.size() == 0 && bus.i_start) begin
                for (int k = 0; k < int'(NSYM); k++) pend_q.push_back(sym_of(bus.i_data, k));
            end
            if (pend_q.size() != 0) begin
                nd  = pend_q.pop_front();
                nv  = 1'b1;
                ndn = (pend_q.size() == 0);
            end
        end
        m_data  <= nd;
        m_valid <= nv;
        m_done  <= ndn;
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("mdl_valid", 32'(bus.o_valid), 32'(m_valid));
            check("mdl_done", 32'(bus.o_done), 32'(m_done));
            check("mdl_data", 32'(bus.o_data), 32'(m_data));
            check("done_without_valid", 32'(bus.o_done & ~bus.o_valid), 32'd0);
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        check({tag, "_done"}, 32'(bus.o_done), 32'd0);
        check({tag, "_data"}, 32'(bus.o_data), 32'd0);
    endtask

    // Called at a negedge: presents the word, then checks all NSYM symbols against seq.
    task automatic run_literal(input logic [IN-1:0] w, input logic [IN-1:0] seq,
                               input string tag);
        bus.i_data  = w;
        bus.i_start = 1'b1;
        for (int k = 0; k < int'(NSYM); k++) begin
            @(negedge clk);
            if (k == 0) bus.i_start = 1'b0;
            check($sformatf("%s_sym%0d", tag, k), 32'(bus.o_data),
                  32'(seq[IN-1-OUT*k -: OUT]));
            check($sformatf("%s_valid%0d", tag, k), 32'(bus.o_valid), 32'd1);
            check($sformatf("%s_done%0d", tag, k), 32'(bus.o_done),
                  32'(k == int'(NSYM) - 1));
        end
        @(negedge clk);
        check_idle({tag, "_after"});
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_data  = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        @(negedge clk);
        run_literal(16'hAAAA, SeqAAAA, "aaaa");
        run_literal(16'h1234, Seq1234, "w1234");

        // Continuous start: two back-to-back words, no bubble.
        bus.i_data  = 16'hAAAA;
        bus.i_start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check($sformatf("cont_valid%0d", c), 32'(bus.o_valid), 32'd1);
            check($sformatf("cont_done%0d", c), 32'(bus.o_done), 32'(c == 8 || c == 16));
            check($sformatf("cont_data%0d", c), 32'(bus.o_data), 32'd2);
            if (c == 16) bus.i_start = 1'b0;
        end
        @(negedge clk);
        check_idle("cont_after");

        // Mid-word data change is ignored; the next word picks it up.
        bus.i_data  = 16'hAAAA;
        bus.i_start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.i_start = 1'b0;
            check($sformatf("chg_data%0d", c), 32'(bus.o_data), 32'd2);
            check($sformatf("chg_done%0d", c), 32'(bus.o_done), 32'(c == 8));
            if (c == 3) bus.i_data = 16'h1234;
        end
        run_literal(16'h1234, Seq1234, "chg_next");

        // Reset on the 4th symbol discards the word.
        bus.i_data  = 16'hAAAA;
        bus.i_start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) bus.i_start = 1'b0;
            check($sformatf("rst_mid_data%0d", c), 32'(bus.o_data), 32'd2);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        rst = 1'b0;
        run_literal(16'h1234, Seq1234, "rst_restart");

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out converter in the Viterbi datapath.
- Captures a SIZE_DATA_IN-bit word on a start request.
- Emits the word as SIZE_DATA_IN/SIZE_DATA_OUT consecutive SIZE_DATA_OUT-bit symbols, one per clock, with a valid strobe and a last-symbol done pulse.
- Feeds downstream per-symbol consumers (e.g. 2-bit code-symbol streams).

Parameters:
- SIZE_DATA_IN, 16, width of parallel input word; must be an integer multiple of SIZE_DATA_OUT.
- SIZE_DATA_OUT, 2, width of each serial output symbol; NUM_SYM = SIZE_DATA_IN/SIZE_DATA_OUT must be >= 2.

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  synchronous active-high reset.
- i_start  input  1  level start request; sampled only in IDLE or on the last-symbol cycle.
- i_data  input  SIZE_DATA_IN  parallel word; sampled on the same edge that accepts i_start.
- o_data  output  SIZE_DATA_OUT  current serial symbol (registered).
- o_valid  output  1  o_data holds a valid symbol this cycle.
- o_done  output  1  one-cycle pulse coincident with the last symbol of a word.

Behaviour:
- One clock, i_clk; reset is synchronous and active-high (i_rst). All state is updated on the rising edge of i_clk.
- Reset (i_rst=1 at an edge): state=IDLE, counter=0, shift register=0, o_data=0, o_valid=0, o_done=0. Reset overrides everything, including mid-word; the partial word is discarded.
- States: IDLE, SHIFT.
- IDLE, i_start=1: capture i_data.
  - o_data <= most-significant symbol i_data[SIZE_DATA_IN-1 -: SIZE_DATA_OUT].
  - o_valid <= 1; shift register <= remaining symbols; counter <= 1; go to SHIFT.
- IDLE, i_start=0: o_valid <= 0, o_done <= 0, o_data <= 0.
- SHIFT: each edge, o_data <= next symbol in MSB-to-LSB order and counter++.
  - When counter reaches NUM_SYM-1, the final symbol is driven and o_done <= 1 on the same cycle as that symbol's o_valid.
- Latency: first symbol is visible on the cycle after the accepting edge. A word occupies exactly NUM_SYM consecutive valid cycles, with no bubbles.
- After the last symbol:
  - If i_start=1 at that edge, a new word is captured and its first symbol follows immediately (o_valid stays 1, o_done drops).
  - Otherwise go to IDLE, with o_valid=0 and o_o_done=0 next cycle.
- i_start and i_data changes during SHIFT, other than at the last-symbol edge, are ignored. The captured word is never modified mid-flight.
- o_done is never high without o_valid.
- Counter width: $clog2(NUM_SYM).

Optional Feature:
- Macro PISO_LSB_FIRST_EN.
- Defined: symbols are emitted least-significant first (i_data[SIZE_DATA_OUT-1:0] first); shift direction is reversed.
- Undefined (default): MSB-first order as above.
- Timing, valid and done behaviour are identical in both builds.

Decomposition:
- Package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t;
  - a localparam/function computing NUM_SYM and counter width from the two parameters.
- A single sub-module, piso_sym_counter, is natural. It is a modulo-NUM_SYM counter with load/enable and a terminal-count output that drives o_done.
- Static parameter check: elaboration error if SIZE_DATA_IN % SIZE_DATA_OUT != 0.

Test Plan:
- Reset then i_start=1, i_data=16'hAAAA for one edge -> 8 cycles of o_data=2'b10 with o_valid=1; o_done=1 only on the 8th; then o_valid=0.
- i_data=16'h1234, MSB-first -> o_data sequence 00,01,00,10,00,11,01,00.
  - With PISO_LSB_FIRST_EN -> 00,01,11,00,10,00,01,00.
  - o_done on the last symbol in both builds.
- i_start held high continuously with 16'hAAAA -> 16 gapless valid cycles (two words); o_done on cycles 8 and 16; o_valid never drops.
- Change i_data to 16'h1234 on cycle 3 of a 16'hAAAA word -> remaining symbols are still 10; the next word (if i_start=1 at the last edge) carries 1234.
- Assert i_rst on the 4th symbol cycle -> the next cycle has o_valid=0, o_done=0, o_data=0; the restart with 16'h1234 then produces the full 8-symbol sequence.
- i_start=0 idle for 10 cycles -> o_valid and o_done stay 0 and o_data stays 0.
